// File: rtl/pulse_meter_pkg.sv
// Shared FSM state type and default parameters for the pulse period meter.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } chan_state_t;

    localparam int unsigned DEF_CHANNELS = 2;
    localparam int unsigned DEF_CNT_W    = 25;
    localparam int unsigned DEF_OUT_W    = 4;
    localparam int unsigned DEF_AVG_LOG2 = 2;

endpackage

// File: rtl/pulse_chan.sv
// One pulse-interval channel: input stage, FSM, saturating counter, filter and publish register.
// Define PULSE_SYNC_EN to place a two-flop synchroniser ahead of the edge register.
module pulse_chan
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned OUT_W       = DEF_OUT_W,
    parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
    parameter int unsigned TIMEOUT_CYC = (1 << CNT_W) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_pulse,
    output logic             o_edge_stb,
    output logic [OUT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_lost
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]      TO_LAST = 32'(TIMEOUT_CYC - 1);

    logic r_s;
    logic r_s_d;

`ifdef PULSE_SYNC_EN
    logic r_meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_s    <= 1'b0;
            r_s_d  <= 1'b0;
        end else begin
            r_meta <= i_pulse;
            r_s    <= r_meta;
            r_s_d  <= r_s;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s   <= 1'b0;
            r_s_d <= 1'b0;
        end else begin
            r_s   <= i_pulse;
            r_s_d <= r_s;
        end
    end
`endif

    logic w_edge;
    assign w_edge     = r_s & ~r_s_d;
    assign o_edge_stb = w_edge;

    chan_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_avg, w_avg_nxt;
    logic             r_lost, w_lost_nxt;

    logic [CNT_W-1:0]        w_period;
    logic signed [CNT_W:0]   w_diff;
    logic signed [CNT_W:0]   w_step;
    logic [CNT_W-1:0]        w_avg_filt;
    logic                    w_cnt_at_to;

    // Period is the cycle distance between edges; the counter holds one less.
    assign w_period    = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
    assign w_diff      = $signed({1'b0, w_period}) - $signed({1'b0, r_avg});
    assign w_step      = w_diff >>> AVG_LOG2;
    assign w_avg_filt  = CNT_W'({1'b0, r_avg} + $unsigned(w_step));
    assign w_cnt_at_to = (32'(r_cnt) == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_avg   <= '0;
            r_lost  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_avg   <= w_avg_nxt;
            r_lost  <= w_lost_nxt;
        end
    end

    // An edge takes priority over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_avg_nxt   = r_avg;
        w_lost_nxt  = r_lost;
        if (w_edge) begin
            w_cnt_nxt  = '0;
            w_lost_nxt = 1'b0;
            case (r_state)
                IDLE:    w_state_nxt = ARMED;
                ARMED: begin
                    w_state_nxt = RUN;
                    w_avg_nxt   = w_period;
                end
                default: w_avg_nxt = w_avg_filt;
            endcase
        end else if (r_state != IDLE) begin
            if (w_cnt_at_to) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_avg_nxt   = '0;
                w_lost_nxt  = 1'b1;
            end else if (r_cnt != CNT_MAX) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    logic [OUT_W-1:0] r_pout;
    logic             r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pout  <= '0;
            r_valid <= 1'b0;
        end else if (i_tick) begin
            r_pout  <= r_avg[CNT_W-1 -: OUT_W];
            r_valid <= (r_state == RUN);
        end
    end

    assign o_period = r_pout;
    assign o_valid  = r_valid;
    assign o_lost   = r_lost;

endmodule

// File: rtl/pulse_period_meter.sv
// Multi-channel pulse-interval meter: one pulse_chan per input, outputs packed per channel.
// Define PULSE_SYNC_EN for asynchronous pulse inputs (adds a two-flop synchroniser per channel).
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CHANNELS    = DEF_CHANNELS,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned OUT_W       = DEF_OUT_W,
    parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
    parameter int unsigned TIMEOUT_CYC = (1 << CNT_W) - 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [CHANNELS-1:0]       pulse_in,
    output logic [CHANNELS-1:0]       edge_stb,
    output logic [CHANNELS*OUT_W-1:0] period_out,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       lost
);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        pulse_chan #(
            .CNT_W       (CNT_W),
            .OUT_W       (OUT_W),
            .AVG_LOG2    (AVG_LOG2),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_tick     (tick),
            .i_pulse    (pulse_in[n]),
            .o_edge_stb (edge_stb[n]),
            .o_period   (period_out[n*OUT_W +: OUT_W]),
            .o_valid    (valid[n]),
            .o_lost     (lost[n])
        );
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: two configurations, expected outputs queued per stream.
module tb_pulse_period_meter;

`ifdef PULSE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        tick  = 1'b0;
    logic [2:0]  pin   = '0;

    logic [1:0]  a_stb, a_valid, a_lost;
    logic [15:0] a_pout;
    logic        b_stb, b_valid, b_lost;
    logic [5:0]  b_pout;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    // Streams: 0 = A ch0, 1 = A ch1, 2 = B ch0
    int sched  [3][$];
    int q_edge [3][$];
    int q_pub  [3][$];
    int q_lost [3][$];

    pulse_period_meter #(
        .CHANNELS(2), .CNT_W(8), .OUT_W(8), .AVG_LOG2(2), .TIMEOUT_CYC(100)
    ) u_a (
        .clk(clk), .reset(reset), .tick(tick), .pulse_in(pin[1:0]),
        .edge_stb(a_stb), .period_out(a_pout), .valid(a_valid), .lost(a_lost)
    );

    pulse_period_meter #(
        .CHANNELS(1), .CNT_W(6), .OUT_W(6), .AVG_LOG2(0), .TIMEOUT_CYC(1000)
    ) u_b (
        .clk(clk), .reset(reset), .tick(tick), .pulse_in(pin[2]),
        .edge_stb(b_stb), .period_out(b_pout), .valid(b_valid), .lost(b_lost)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_edges(input int s, input int first, input int step, input int count);
        for (int i = 0; i < count; i++) sched[s].push_back(first + i * step);
    endtask

    task automatic exp_pub(input int s, input int v, input int p);
        q_pub[s].push_back(v * 256 + p);
    endtask

    function automatic int pub_of(input int s);
        case (s)
            0:       return int'({a_valid[0], a_pout[7:0]});
            1:       return int'({a_valid[1], a_pout[15:8]});
            default: return int'({b_valid, 2'b00, b_pout});
        endcase
    endfunction

    function automatic logic stb_of(input int s);
        case (s)
            0:       return a_stb[0];
            1:       return a_stb[1];
            default: return b_stb;
        endcase
    endfunction

    function automatic int lost_of(input int s);
        case (s)
            0:       return int'(a_lost[0]);
            1:       return int'(a_lost[1]);
            default: return int'(b_lost);
        endcase
    endfunction

    // Driver: pulses held high 3 cycles; expected edge_stb cycle queued when issued
    initial begin
        int hold [3];
        hold = '{0, 0, 0};
        forever begin
            @(negedge clk);
            tick = (cyc % 3 == 0);
            for (int s = 0; s < 3; s++) begin
                if (sched[s].size() > 0 && sched[s][0] == cyc) begin
                    void'(sched[s].pop_front());
                    hold[s] = 3;
                    q_edge[s].push_back(cyc + LAT);
                end
                pin[s] = (hold[s] > 0);
                if (hold[s] > 0) hold[s]--;
            end
        end
    end

    // Monitor: compare on every edge strobe and every change of published / lost outputs
    initial begin
        int prev_pub  [3];
        int prev_lost [3];
        int cur;
        prev_pub  = '{0, 0, 0};
        prev_lost = '{0, 0, 0};
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 3; s++) begin
                if (stb_of(s)) begin
                    if (q_edge[s].size() > 0)
                        chk($sformatf("edge_stb_cycle[%0d]", s), cyc, q_edge[s].pop_front());
                    else
                        chk($sformatf("edge_stb_unexpected[%0d]", s), 1, 0);
                end
                cur = pub_of(s);
                if (cur != prev_pub[s]) begin
                    if (q_pub[s].size() > 0)
                        chk($sformatf("publish{valid,period}[%0d]", s), cur, q_pub[s].pop_front());
                    else
                        chk($sformatf("publish_unexpected[%0d]", s), cur, prev_pub[s]);
                    prev_pub[s] = cur;
                end
                cur = lost_of(s);
                if (cur != prev_lost[s]) begin
                    if (q_lost[s].size() > 0)
                        chk($sformatf("lost[%0d]", s), cur, q_lost[s].pop_front());
                    else
                        chk($sformatf("lost_unexpected[%0d]", s), cur, prev_lost[s]);
                    prev_lost[s] = cur;
                end
            end
        end
    end

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_period_out", int'({a_pout, b_pout}), 0);
        chk("reset_flags", int'({a_stb, a_valid, a_lost, b_stb, b_valid, b_lost}), 0);
        reset = 1'b0;

        // B: no filter, period 20, then a 100-cycle gap saturating at 63
        push_edges(2, 10, 20, 3);
        push_edges(2, 150, 20, 2);
        exp_pub(2, 1, 20);
        exp_pub(2, 1, 63);
        exp_pub(2, 1, 20);

        // A ch0: period 16, gap of exactly TIMEOUT (edge wins), then 101 (timeout first)
        push_edges(0, 20, 16, 4);
        push_edges(0, 168, 16, 2);
        push_edges(0, 285, 16, 13);
        exp_pub(0, 1, 16);
        exp_pub(0, 1, 37);
        exp_pub(0, 1, 31);
        exp_pub(0, 0, 0);
        exp_pub(0, 1, 16);
        q_lost[0].push_back(1);
        q_lost[0].push_back(0);

        // A ch1: periods 40,40,80,80 -> avg 40,40,50,57; silence -> lost; then period 24
        push_edges(1, 20, 40, 3);
        push_edges(1, 180, 80, 2);
        push_edges(1, 400, 24, 4);
        exp_pub(1, 1, 40);
        exp_pub(1, 1, 50);
        exp_pub(1, 1, 57);
        exp_pub(1, 0, 0);
        exp_pub(1, 1, 24);
        q_lost[1].push_back(1);
        q_lost[1].push_back(0);

        while (cyc < 489) @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 3; s++) exp_pub(s, 0, 0);
        #1;
        chk("midrun_reset_period_out", int'({a_pout, b_pout}), 0);
        chk("midrun_reset_valid", int'({a_valid, b_valid}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // After reset every FSM restarts in IDLE: first edge only arms
        push_edges(0, 500, 16, 5);
        push_edges(1, 500, 24, 4);
        push_edges(2, 500, 40, 2);
        exp_pub(0, 1, 16);
        exp_pub(1, 1, 24);
        exp_pub(2, 1, 40);

        while (cyc < 620) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("edge_pending[%0d]", s), q_edge[s].size(), 0);
            chk($sformatf("publish_pending[%0d]", s), q_pub[s].size(), 0);
            chk($sformatf("lost_pending[%0d]", s), q_lost[s].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
